uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, next generation of the team's fixed 8N1 transmitter. Adds configurable data width, parity, stop-bit count, baud divisor and an input FIFO, so a producer can queue words while a frame is on the line. It sits between a byte/word producer and the serial pin; frames go out back-to-back with no idle gap while the FIFO holds data.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
CLKS_PER_BIT, 8, clk cycles per serial bit, legal >= 2
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, legal 1 or 2
FIFO_DEPTH, 4, input FIFO entries, power of 2, legal >= 2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
data  input  DATA_BITS  word to transmit, sampled when start & ready
start  input  1  push request; word accepted on an edge where start & ready
tx  output  1  serial line, registered, idle high
ready  output  1  combinational, high when fifo_count != FIFO_DEPTH
busy  output  1  high while a frame is on the line (state != IDLE)
fifo_count  output  $clog2(FIFO_DEPTH)+1  words queued, not including the frame in flight

Behaviour:
- Reset (async, while rst high): tx=1, busy=0, fifo_count=0, ready=1. FIFO pointers cleared and contents discarded. FSM goes to IDLE. Reset mid-frame aborts the frame and tx goes high immediately.
- FIFO: push on start & ready. start while full is ignored; no overflow flag.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states and order: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE or START.
- IDLE with fifo_count > 0 at an edge:
  - pop the head word into the shift register;
  - tx <= 0, baud counter <= 0, state <= START.
- Latency: word pushed into an empty idle block at edge N; tx falls at edge N+1.
- Bit timing:
  - Every bit (start, data, parity, each stop) holds tx for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1 and restarts at each bit boundary.
  - The counter is held at 0 in IDLE; it is not free-running.
- DATA: LSB first, DATA_BITS bits; a bit index counter selects the bit.
- PARITY: computed at pop time over the popped word.
  - Even: bit = XOR of data bits.
  - Odd: bit = inverted XOR of data bits.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle:
  - FIFO non-empty: pop and go straight to START (tx falls on the next edge, zero idle cycles).
  - FIFO empty: go to IDLE, busy falls.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- The data input is never read after the push; changing it mid-frame has no effect.
- Illegal parameter values are not supported. Simulation-only checks flag them.

Test Plan:
- Defaults, push 0xA5 once -> tx falls 1 cycle after accept; line = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; busy high 80 cycles; then tx=1, busy=0.
- PARITY=2, push 0x07 -> parity bit 1, frame 88 cycles. PARITY=1, push 0x00 -> parity bit 1. PARITY=1, push 0x01 -> parity bit 0.
- FIFO_DEPTH=4, start held high 6 consecutive cycles with 0x11..0x16 from idle:
  - 0x11..0x15 accepted, 0x16 dropped;
  - ready falls after the 5th accept and fifo_count=4;
  - five frames sent back-to-back with no idle cycle between the stop bit and the next start bit.
- DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4, push 0x55 -> 7 data bits 1,0,1,0,1,0,1, then tx high 8 cycles; total 40 cycles.
- Assert rst asynchronously mid-DATA with 2 words queued -> tx=1, busy=0, fifo_count=0 without waiting for a clock edge; no frame resumes after release. A new push then transmits normally.
- Push and pop on the same edge (push during the last stop cycle with 1 word queued) -> fifo_count stays 1; both words are transmitted in order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format and an input FIFO.
// Queued words go out back-to-back with no idle gap between frames.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          start,
    output logic                          tx,
    output logic                          ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_param_check
        $error("uart_tx_fifo: illegal parameter combination");
    end

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
        return (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic [2:0]           r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_last;
    logic                 w_stop_last;
    logic                 w_data_last;
    logic                 w_fifo_empty;
    logic [BIT_W-1:0]     w_bit_nxt;

    assign w_fifo_empty = (r_count == '0);
    assign w_baud_last  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_stop_last  = (r_stop_idx == 1'(STOP_BITS - 1));
    assign w_data_last  = (r_bit_idx == BIT_W'(DATA_BITS - 1));
    assign w_bit_nxt    = w_data_last ? '0 : r_bit_idx + 1'b1;

    assign ready      = (r_count != CW'(FIFO_DEPTH));
    assign w_push     = start & ready;
    // Pop either from idle or on the final stop cycle so the next start bit follows with no gap.
    assign w_pop      = !w_fifo_empty &&
                        ((r_state == S_IDLE) ||
                         (r_state == S_STOP && w_baud_last && w_stop_last));
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
        if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_par   <= parity_bit(r_mem[r_rd_ptr]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (!w_fifo_empty) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (w_data_last) begin
                            if (PARITY != 0) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_idx <= 1'b0;
                                r_state    <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= w_bit_nxt;
                            r_tx      <= r_shift[w_bit_nxt];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_baud_last) begin
                        r_baud     <= '0;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (w_stop_last) begin
                            if (!w_fifo_empty) begin
                                r_tx    <= 1'b0;
                                r_state <= S_START;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a scoreboard of pushed words is checked
// against frames decoded bit-by-bit from the serial line of several configurations.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [6:0] d3 = '0;
    logic       st0 = 0, st1 = 0, st2 = 0, st3 = 0;
    logic       tx0, tx1, tx2, tx3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       bsy0, bsy1, bsy2, bsy3;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] sb[$];

    uart_tx_fifo u0 (
        .clk(clk), .rst(rst), .data(d0), .start(st0), .tx(tx0),
        .ready(rdy0), .busy(bsy0), .fifo_count(cnt0));
    uart_tx_fifo #(.PARITY(2)) u1 (
        .clk(clk), .rst(rst), .data(d1), .start(st1), .tx(tx1),
        .ready(rdy1), .busy(bsy1), .fifo_count(cnt1));
    uart_tx_fifo #(.PARITY(1)) u2 (
        .clk(clk), .rst(rst), .data(d2), .start(st2), .tx(tx2),
        .ready(rdy2), .busy(bsy2), .fifo_count(cnt2));
    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .CLKS_PER_BIT(4)) u3 (
        .clk(clk), .rst(rst), .data(d3), .start(st3), .tx(tx3),
        .ready(rdy3), .busy(bsy3), .fifo_count(cnt3));

    function automatic logic tx_of(input int s);
        case (s)
            1: return tx1;
            2: return tx2;
            3: return tx3;
            default: return tx0;
        endcase
    endfunction

    function automatic logic busy_of(input int s);
        case (s)
            1: return bsy1;
            2: return bsy2;
            3: return bsy3;
            default: return bsy0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int sel, input logic [8:0] w, input bit accepted);
        @(negedge clk);
        case (sel)
            1: begin d1 = w[7:0]; st1 = 1'b1; end
            2: begin d2 = w[7:0]; st2 = 1'b1; end
            3: begin d3 = w[6:0]; st3 = 1'b1; end
            default: begin d0 = w[7:0]; st0 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        st0 = 0; st1 = 0; st2 = 0; st3 = 0;
        // Scramble the data inputs: the frame must come from the queued copy.
        d0 = ~w[7:0]; d1 = ~w[7:0]; d2 = ~w[7:0]; d3 = ~w[6:0];
        if (accepted) sb.push_back(w);
    endtask

    task automatic recv_frame(input int sel, input int dbits, input int cpb, input int par,
                              input int stops, input int exp_wait, input bit idle_after);
        int         waited;
        int         nb;
        logic [8:0] w;
        logic       bits [0:12];
        logic       p;
        logic       obs;
        bit         ok_busy;
        waited = 0;
        @(negedge clk);
        while (tx_of(sel) !== 1'b0 && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 400) begin
            chk($sformatf("u%0d_start_seen", sel), tx_of(sel), 0);
            return;
        end
        if (exp_wait >= 0) chk($sformatf("u%0d_start_latency", sel), waited, exp_wait);
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", sb.size(), 1);
            w = '0;
        end else begin
            w = sb.pop_front();
        end
        nb = 0;
        bits[nb] = 1'b0; nb++;
        p = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            bits[nb] = w[i]; nb++;
            p = p ^ w[i];
        end
        if (par != 0) begin
            bits[nb] = (par == 1) ? ~p : p; nb++;
        end
        for (int s = 0; s < stops; s++) begin
            bits[nb] = 1'b1; nb++;
        end
        ok_busy = 1;
        for (int b = 0; b < nb; b++) begin
            obs = bits[b];
            for (int c = 0; c < cpb; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (tx_of(sel) !== bits[b]) obs = tx_of(sel);
                if (busy_of(sel) !== 1'b1) ok_busy = 0;
            end
            chk($sformatf("u%0d_w%0h_bit%0d", sel, w, b), obs, bits[b]);
        end
        chk($sformatf("u%0d_w%0h_busy_frame", sel, w), ok_busy, 1);
        if (idle_after) begin
            @(negedge clk);
            chk($sformatf("u%0d_idle_tx", sel), tx_of(sel), 1);
            chk($sformatf("u%0d_idle_busy", sel), busy_of(sel), 0);
        end
    endtask

    initial begin
        #300000;
        $error("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  exp_cnt [6];
        bit  exp_rdy [6];
        bit  ok;
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        exp_rdy = '{1, 1, 1, 1, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx0, 1);
        chk("rst_busy", bsy0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_tx_u3", tx3, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames in each configuration
        push(0, 9'h0A5, 1);
        recv_frame(0, 8, 8, 0, 1, 1, 1);
        push(1, 9'h007, 1);
        recv_frame(1, 8, 8, 2, 1, 1, 1);
        push(2, 9'h000, 1);
        recv_frame(2, 8, 8, 1, 1, 1, 1);
        push(2, 9'h001, 1);
        recv_frame(2, 8, 8, 1, 1, 1, 1);
        push(3, 9'h055, 1);
        recv_frame(3, 7, 4, 0, 2, 1, 1);

        // Start held for six cycles from idle: five accepted, sixth dropped
        fork
            begin
                @(negedge clk);
                st0 = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    d0 = 8'h11 + 8'(i);
                    @(posedge clk);
                    #1;
                    if (i < 5) sb.push_back(9'(8'h11 + 8'(i)));
                    chk($sformatf("fill_count_%0d", i), cnt0, exp_cnt[i]);
                    chk($sformatf("fill_ready_%0d", i), rdy0, exp_rdy[i]);
                end
                st0 = 1'b0;
            end
            begin
                recv_frame(0, 8, 8, 0, 1, -1, 0);
                recv_frame(0, 8, 8, 0, 1, 0, 0);
                recv_frame(0, 8, 8, 0, 1, 0, 0);
                recv_frame(0, 8, 8, 0, 1, 0, 0);
                recv_frame(0, 8, 8, 0, 1, 0, 1);
            end
        join
        chk("fill_sb_drained", sb.size(), 0);

        // Asynchronous reset in the middle of the data bits with two words queued
        push(0, 9'h0F0, 0);
        push(0, 9'h00F, 0);
        push(0, 9'h033, 0);
        chk("pre_rst_count", cnt0, 2);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", tx0, 1);
        chk("async_rst_busy", bsy0, 0);
        chk("async_rst_count", cnt0, 0);
        chk("async_rst_ready", rdy0, 1);
        @(negedge clk);
        rst = 1'b0;
        ok = 1;
        repeat (120) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || bsy0 !== 1'b0) ok = 0;
        end
        chk("no_resume_after_rst", ok, 1);
        push(0, 9'h03C, 1);
        recv_frame(0, 8, 8, 0, 1, 1, 1);

        // Push coinciding with the pop on the final stop cycle
        fork
            begin
                push(0, 9'h05A, 1);
                @(posedge clk);
                push(0, 9'h0C3, 1);
                chk("queued_one", cnt0, 1);
                repeat (78) @(posedge clk);
                push(0, 9'h096, 1);
                chk("pushpop_count", cnt0, 1);
            end
            begin
                recv_frame(0, 8, 8, 0, 1, -1, 0);
                recv_frame(0, 8, 8, 0, 1, 0, 0);
                recv_frame(0, 8, 8, 0, 1, 0, 1);
            end
        join
        chk("final_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
